// File: rtl/ppg_phase_sequencer_if.sv
// Bundle between the config/ADC side and the PPG phase sequencer.
// master = register/config + ADC source, slave = the sequencer.
interface ppg_phase_sequencer_if #(
   parameter int ADC_W = 8
);
   logic             enable;
   logic [3:0]       red_drive;
   logic [3:0]       ir_drive;
   logic [6:0]       red_dc_comp;
   logic [6:0]       ir_dc_comp;
   logic [3:0]       red_gain;
   logic [3:0]       ir_gain;
   logic [ADC_W-1:0] ADC;
   logic             LED_RED;
   logic             LED_IR;
   logic [3:0]       LED_Drive;
   logic [6:0]       DC_Comp;
   logic [3:0]       PGA_Gain;
   logic [1:0]       phase;
   logic [ADC_W-1:0] red_sample;
   logic [ADC_W-1:0] ir_sample;
   logic [ADC_W-1:0] dark_sample;
   logic             sample_valid;

   modport master (
      output enable, red_drive, ir_drive, red_dc_comp, ir_dc_comp, red_gain, ir_gain, ADC,
      input  LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain, phase,
             red_sample, ir_sample, dark_sample, sample_valid
   );

   modport slave (
      input  enable, red_drive, ir_drive, red_dc_comp, ir_dc_comp, red_gain, ir_gain, ADC,
      output LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain, phase,
             red_sample, ir_sample, dark_sample, sample_valid
   );
endinterface

// File: rtl/ppg_phase_sequencer.sv
// RED -> IR -> DARK phase sequencer for the fingerclip front end with per-phase ADC averaging.
// Optional macro AMBIENT_SUB_EN: subtract the dark average from red/ir (clamped at 0) when publishing.
module ppg_phase_sequencer #(
   parameter int PHASE_CYC  = 250,
   parameter int SETTLE_CYC = 50,
   parameter int AVG_LOG2   = 3,
   parameter int ADC_W      = 8
) (
   input logic                  clk,
   input logic                  rst,
   ppg_phase_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, RED = 2'd1, IR = 2'd2, DARK = 2'd3} state_t;

   localparam int CNT_W = $clog2(PHASE_CYC + 1);
   localparam int ACC_W = ADC_W + AVG_LOG2;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYC - 1);
   localparam logic [CNT_W-1:0] WIN_LO   = CNT_W'(SETTLE_CYC);
   localparam logic [CNT_W-1:0] WIN_HI   = CNT_W'(SETTLE_CYC + 2**AVG_LOG2);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc, acc_next;
   logic [ADC_W-1:0] avg_next, red_avg, ir_avg, red_pub, ir_pub;
   logic             last, in_window, load_cfg;

   logic [3:0] sh_red_drive, sh_ir_drive, sh_red_gain, sh_ir_gain;
   logic [6:0] sh_red_dc, sh_ir_dc;
   logic [3:0] cfg_red_drive, cfg_ir_drive, cfg_red_gain, cfg_ir_gain;
   logic [6:0] cfg_red_dc, cfg_ir_dc;

   logic       led_red_next, led_ir_next;
   logic [3:0] drive_next, gain_next;
   logic [6:0] dc_next;

   assign last      = (state != IDLE) && (cnt == CNT_LAST);
   assign in_window = (state != IDLE) && (cnt >= WIN_LO) && (cnt < WIN_HI);
   assign acc_next  = in_window ? acc + ACC_W'(bus.ADC) : acc;
   assign avg_next  = acc_next[ACC_W-1:AVG_LOG2];
   assign bus.phase = state;

   // The entering phase sees freshly latched config on a load cycle, otherwise the shadows.
   assign cfg_red_drive = load_cfg ? bus.red_drive   : sh_red_drive;
   assign cfg_ir_drive  = load_cfg ? bus.ir_drive    : sh_ir_drive;
   assign cfg_red_dc    = load_cfg ? bus.red_dc_comp : sh_red_dc;
   assign cfg_ir_dc     = load_cfg ? bus.ir_dc_comp  : sh_ir_dc;
   assign cfg_red_gain  = load_cfg ? bus.red_gain    : sh_red_gain;
   assign cfg_ir_gain   = load_cfg ? bus.ir_gain     : sh_ir_gain;

`ifdef AMBIENT_SUB_EN
   assign red_pub = (red_avg > avg_next) ? red_avg - avg_next : '0;
   assign ir_pub  = (ir_avg  > avg_next) ? ir_avg  - avg_next : '0;
`else
   assign red_pub = red_avg;
   assign ir_pub  = ir_avg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next   = state;
      load_cfg     = 1'b0;
      led_red_next = 1'b0;
      led_ir_next  = 1'b0;
      drive_next   = '0;
      dc_next      = '0;
      gain_next    = '0;
      unique case (state)
         IDLE: if (bus.enable) begin
            state_next = RED;
            load_cfg   = 1'b1;
         end
         RED:  if (last) state_next = IR;
         IR:   if (last) state_next = DARK;
         DARK: if (last) begin
            if (bus.enable) begin
               state_next = RED;
               load_cfg   = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      unique case (state_next)
         RED: begin
            led_red_next = 1'b1;
            drive_next   = cfg_red_drive;
            dc_next      = cfg_red_dc;
            gain_next    = cfg_red_gain;
         end
         IR: begin
            led_ir_next = 1'b1;
            drive_next  = cfg_ir_drive;
            dc_next     = cfg_ir_dc;
            gain_next   = cfg_ir_gain;
         end
         DARK: begin
            dc_next   = cfg_red_dc;
            gain_next = cfg_red_gain;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt              <= '0;
         acc              <= '0;
         red_avg          <= '0;
         ir_avg           <= '0;
         sh_red_drive     <= '0;
         sh_ir_drive      <= '0;
         sh_red_dc        <= '0;
         sh_ir_dc         <= '0;
         sh_red_gain      <= '0;
         sh_ir_gain       <= '0;
         bus.LED_RED      <= 1'b0;
         bus.LED_IR       <= 1'b0;
         bus.LED_Drive    <= '0;
         bus.DC_Comp      <= '0;
         bus.PGA_Gain     <= '0;
         bus.red_sample   <= '0;
         bus.ir_sample    <= '0;
         bus.dark_sample  <= '0;
         bus.sample_valid <= 1'b0;
      end else begin
         if (load_cfg) begin
            sh_red_drive <= bus.red_drive;
            sh_ir_drive  <= bus.ir_drive;
            sh_red_dc    <= bus.red_dc_comp;
            sh_ir_dc     <= bus.ir_dc_comp;
            sh_red_gain  <= bus.red_gain;
            sh_ir_gain   <= bus.ir_gain;
         end
         cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
         acc <= last ? '0 : acc_next;
         if (last && state == RED) red_avg <= avg_next;
         if (last && state == IR)  ir_avg  <= avg_next;
         // The dark average is published straight from the accumulator, it never needs its own register.
         bus.sample_valid <= last && (state == DARK);
         if (last && state == DARK) begin
            bus.red_sample  <= red_pub;
            bus.ir_sample   <= ir_pub;
            bus.dark_sample <= avg_next;
         end
         bus.LED_RED   <= led_red_next;
         bus.LED_IR    <= led_ir_next;
         bus.LED_Drive <= drive_next;
         bus.DC_Comp   <= dc_next;
         bus.PGA_Gain  <= gain_next;
      end
   end
endmodule

// File: tb/tb_ppg_phase_sequencer.sv
// Self-checking bench for ppg_phase_sequencer with PHASE_CYC=16, SETTLE_CYC=4, AVG_LOG2=3.
// Define AMBIENT_SUB_EN for both bench and RTL to check the ambient-subtracting build.
module tb_ppg_phase_sequencer;
   localparam int PHASE_CYC  = 16;
   localparam int SETTLE_CYC = 4;
   localparam int AVG_LOG2   = 3;
   localparam int ADC_W      = 8;
   localparam int FRAME      = 3 * PHASE_CYC;

   logic clk = 1'b0;
   logic rst;

   ppg_phase_sequencer_if #(.ADC_W(ADC_W)) bus ();

   ppg_phase_sequencer #(
      .PHASE_CYC (PHASE_CYC),
      .SETTLE_CYC(SETTLE_CYC),
      .AVG_LOG2  (AVG_LOG2),
      .ADC_W     (ADC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] dr, di, gr, gi;
      logic [6:0] cr, ci;
   } cfg_t;

   // mode 0: constant per phase, 1: ADC = cnt, 2: value in window / 255 outside, 3: value + (cnt & 1)
   typedef struct {
      int         mode;
      int         r, i, d;
      logic [7:0] er, ei, ed;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t vec[6];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input cfg_t c);
      bus.red_drive   = c.dr;
      bus.ir_drive    = c.di;
      bus.red_dc_comp = c.cr;
      bus.ir_dc_comp  = c.ci;
      bus.red_gain    = c.gr;
      bus.ir_gain     = c.gi;
   endtask

   function automatic cfg_t mkCfg(input int s);
      cfg_t c;
      c.dr = 4'(s + 1);
      c.di = 4'(s + 6);
      c.cr = 7'(s * 9 + 3);
      c.ci = 7'(s * 5 + 40);
      c.gr = 4'(s + 2);
      c.gi = 4'(15 - s);
      return c;
   endfunction

   // {LED_RED, LED_IR, LED_Drive, DC_Comp, PGA_Gain, phase}
   function automatic logic [18:0] expDrive(input cfg_t c, input int ph);
      case (ph)
         1:       return {1'b1, 1'b0, c.dr, c.cr, c.gr, 2'd1};
         2:       return {1'b0, 1'b1, c.di, c.ci, c.gi, 2'd2};
         3:       return {1'b0, 1'b0, 4'd0, c.cr, c.gr, 2'd3};
         default: return '0;
      endcase
   endfunction

   function automatic logic [18:0] actDrive();
      return {bus.LED_RED, bus.LED_IR, bus.LED_Drive, bus.DC_Comp, bus.PGA_Gain, bus.phase};
   endfunction

   function automatic logic [7:0] adcVal(input vec_t v, input int k);
      int c, base, res;
      logic win;
      c    = k % PHASE_CYC;
      base = (k < PHASE_CYC) ? v.r : (k < 2 * PHASE_CYC) ? v.i : v.d;
      win  = (c >= SETTLE_CYC) && (c < SETTLE_CYC + 8);
      case (v.mode)
         1:       res = c;
         2:       res = win ? base : 255;
         3:       res = base + (c & 1);
         default: res = base;
      endcase
      return 8'(res);
   endfunction

   // Entered at cycle 0 of a RED phase; returns at the first cycle after the DARK phase.
   task automatic runFrame(input vec_t v, input cfg_t cur, input cfg_t nxt, input int apply_at, input int drop_at);
      logic early = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         if (k == apply_at) applyStimulus(nxt);
         if (k == drop_at) bus.enable = 1'b0;
         bus.ADC = adcVal(v, k);
         if (k > 0 && bus.sample_valid) early = 1'b1;
         if (k == 0 || k == 12 || k == 16 || k == 32)
            checkOutput($sformatf("drive_k%0d", k), 64'(actDrive()), 64'(expDrive(cur, k / PHASE_CYC + 1)));
         tick();
      end
      checkOutput("no_early_strobe", 64'(early), 64'(0));
      checkOutput("strobe", 64'(bus.sample_valid), 64'(1));
      checkOutput("samples", 64'({bus.red_sample, bus.ir_sample, bus.dark_sample}), 64'({v.er, v.ei, v.ed}));
   endtask

   initial begin
      logic extra;
`ifdef AMBIENT_SUB_EN
      vec[0] = '{0, 100, 60, 20, 8'd80, 8'd40, 8'd20};
      vec[1] = '{1, 0, 0, 0, 8'd0, 8'd0, 8'd7};
      vec[2] = '{0, 255, 255, 255, 8'd0, 8'd0, 8'd255};
      vec[3] = '{0, 30, 90, 50, 8'd0, 8'd40, 8'd50};
      vec[4] = '{2, 10, 20, 5, 8'd5, 8'd15, 8'd5};
      vec[5] = '{3, 40, 70, 12, 8'd28, 8'd58, 8'd12};
`else
      vec[0] = '{0, 100, 60, 20, 8'd100, 8'd60, 8'd20};
      vec[1] = '{1, 0, 0, 0, 8'd7, 8'd7, 8'd7};
      vec[2] = '{0, 255, 255, 255, 8'd255, 8'd255, 8'd255};
      vec[3] = '{0, 30, 90, 50, 8'd30, 8'd90, 8'd50};
      vec[4] = '{2, 10, 20, 5, 8'd10, 8'd20, 8'd5};
      vec[5] = '{3, 40, 70, 12, 8'd40, 8'd70, 8'd12};
`endif
      rst        = 1'b1;
      bus.enable = 1'b0;
      bus.ADC    = '0;
      applyStimulus(mkCfg(0));
      repeat (2) tick();
      checkOutput("reset_drive", 64'(actDrive()), 64'(0));
      checkOutput("reset_samples", 64'({bus.red_sample, bus.ir_sample, bus.dark_sample, bus.sample_valid}), 64'(0));
      rst = 1'b0;
      repeat (3) tick();
      checkOutput("idle_hold", 64'(actDrive()), 64'(0));

      bus.enable = 1'b1;
      tick();
      // Frame 3 changes config mid-RED; the new values must only show in frame 4.
      for (int n = 0; n < 6; n++)
         runFrame(vec[n], mkCfg(n), mkCfg(n + 1), (n == 3) ? 8 : 40, -1);

      // enable dropped during IR: frame completes, one strobe, then IDLE.
      runFrame(vec[0], mkCfg(6), mkCfg(7), 40, 20);
      checkOutput("idle_after_drop", 64'(actDrive()), 64'(0));
      extra = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.sample_valid || bus.phase != 2'd0) extra = 1'b1;
      end
      checkOutput("single_strobe_idle", 64'(extra), 64'(0));
      checkOutput("samples_hold", 64'({bus.red_sample, bus.ir_sample, bus.dark_sample}),
                  64'({vec[0].er, vec[0].ei, vec[0].ed}));

      // rst pulsed mid-IR aborts the frame; restart must begin at RED cnt=0.
      bus.enable = 1'b1;
      tick();
      checkOutput("restart_red", 64'(actDrive()), 64'(expDrive(mkCfg(7), 1)));
      bus.ADC = 8'd77;
      repeat (20) tick();
      checkOutput("pre_reset_ir", 64'(actDrive()), 64'(expDrive(mkCfg(7), 2)));
      rst = 1'b1;
      #1;
      checkOutput("async_reset_drive", 64'(actDrive()), 64'(0));
      checkOutput("async_reset_samples", 64'({bus.red_sample, bus.ir_sample, bus.dark_sample, bus.sample_valid}), 64'(0));
      tick();
      rst = 1'b0;
      tick();
      runFrame(vec[4], mkCfg(7), mkCfg(8), 40, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
